vlsu_axi_order_ctrl: RTL and testbench
======================================

# vlsu_axi_order_ctrl

Issue controller placed between the vector address generator and the AXI cut on the AR and AW channels. It gates address-channel valid/ready, observes R and B handshakes to count outstanding read and write bursts, and enforces a per-direction outstanding limit. When enabled, it also enforces strict load/store ordering between the two channels. It provides a fence/drain handshake so the dispatcher can wait for all vector memory traffic to retire. Payloads (addresses, lengths, IDs) bypass this block; only handshake signals pass through it.

## Interface
- MaxOutstanding, 8, maximum un-retired bursts per direction; must be ≥1.
- CntWidth, $clog2(MaxOutstanding+1), localparam, counter width.

- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- ordering_en_i  in  1  1: an AR may not issue while writes are outstanding, and an AW may not issue while reads are outstanding.
- fence_req_i  in  1  level; blocks new address issue and requests drain.
- fence_done_o  out  1  registered; fence complete.
- us_ar_valid_i / us_ar_ready_o  in/out  1  AR handshake from the address generator.
- ar_valid_o / ar_ready_i  out/in  1  AR handshake toward the AXI cut.
- us_aw_valid_i / us_aw_ready_o  in/out  1  AW handshake from the address generator.
- aw_valid_o / aw_ready_i  out/in  1  AW handshake toward the AXI cut.
- r_valid_i, r_ready_i, r_last_i  in  1  observed R handshake (ready is driven by the load unit).
- b_valid_i, b_ready_i  in  1  observed B handshake.
- rd_outstanding_o  out  CntWidth  outstanding read bursts.
- wr_outstanding_o  out  CntWidth  outstanding write bursts.
- idle_o  out  1  both counters are zero and state is IDLE.
- protocol_err_o  out  1  sticky; a response arrived while the corresponding counter was zero.

## Operation
- Events:
  - ar_fire = ar_valid_o & ar_ready_i.
  - aw_fire = aw_valid_o & aw_ready_i.
  - r_ret = r_valid_i & r_ready_i & r_last_i.
  - b_ret = b_valid_i & b_ready_i.
- Counters:
  - rd_cnt += ar_fire, −= r_ret; wr_cnt likewise with aw_fire/b_ret.
  - A simultaneous increment and decrement leaves the counter unchanged.
  - A decrement at zero saturates at 0 and sets protocol_err_o, which is cleared only by reset.
- Eligibility:
  - ar_elig = us_ar_valid_i & !fence_req_i & rd_cnt<MaxOutstanding & (!ordering_en_i | wr_cnt==0).
  - aw_elig is symmetric: uses us_aw_valid_i, wr_cnt, and rd_cnt.
- Hold FSM, states IDLE, AR_HOLD, AW_HOLD, BOTH_HOLD:
  - Presenting a valid that does not fire moves the FSM into the matching HOLD state.
  - While in a HOLD state, that channel's valid is forced high regardless of eligibility, fence, or ordering_en_i changes, so AXI valid is never retracted.
  - The HOLD state exits on that channel's fire.
- Grant in IDLE when ordering_en_i=1 and both channels are eligible:
  - Only the channel selected by prio_q is presented.
  - prio_q=0 selects AR; prio_q toggles on every fire to alternate.
- Grant when ordering_en_i=0: AR and AW are independent, each gated only by its own eligibility.
- BOTH_HOLD is reachable only when ordering_en_i=0.
- Pass-through gating:
  - ar_valid_o = (ar_elig & granted) | ar_hold.
  - us_ar_ready_o = ar_ready_i & ar_valid_o.
  - AW is symmetric.
- Fence:
  - No new channel is presented while fence_req_i=1; holds in progress still complete.
  - fence_done_o goes to 1 one cycle after fence_req_i & rd_cnt==0 & wr_cnt==0 & state==IDLE, and stays 1 while that holds.
  - fence_done_o clears the cycle after fence_req_i drops.

## Timing
- Valid/ready gating is combinational: zero added latency, and no path from any ready input to any valid output.
- Counters, state, prio_q, fence_done_o, and protocol_err_o are registered; the counter outputs reflect the previous cycle's events.
- Reset values:
  - Registers: counters 0, state IDLE, prio_q 0, fence_done_o 0, protocol_err_o 0.
  - Combinational outputs: ar_valid_o/aw_valid_o/ready outputs 0 unless an upstream valid is present, idle_o 1.
- Reset mid-burst discards all counts; responses arriving afterward raise protocol_err_o.
- Counter-full: a new AR is blocked when rd_cnt==MaxOutstanding.
- Counter-full with a retiring burst: if an r_ret occurs in the same cycle, the AR is still blocked that cycle (eligibility uses the registered count) and is eligible the next cycle.
- The same full-counter rules apply to AW with wr_cnt and b_ret.
- Write ordering in IDLE with ordering_en_i=1: an AR is issued at the earliest one cycle after the b_ret that brings wr_cnt to 0.

## Test plan
- Reset, then 3 ARs with ar_ready_i=1, then 3 R-last beats: rd_outstanding_o steps 1,2,3 then back to 0; idle_o=1 at the end; protocol_err_o=0.
- MaxOutstanding=2, ordering off, 3 back-to-back ARs: third AR blocked (ar_valid_o=0) until first r_ret; it issues the cycle after.
- Ordering on, AW accepted (wr_cnt=1), then AR requested: ar_valid_o stays 0 until b_ret; issues next cycle. With both requesting at counts 0: AR granted first, then AW waits for rd_cnt==0.
- Ordering on, AR presented with ar_ready_i=0 for 4 cycles while AW valid and fence_req_i toggles: ar_valid_o stays 1 until fire, AW never presented meanwhile.
- fence_req_i=1 with rd_cnt=2, wr_cnt=1: no new issue; fence_done_o rises 1 cycle after last retirement; drops 1 cycle after fence_req_i=0.
- b_valid_i&b_ready_i with wr_cnt=0: wr_outstanding_o stays 0, protocol_err_o=1 until rst_ni asserted.

Source files
------------

// File: rtl/vlsu_axi_order_if.sv
// AR/AW issue handshakes plus observed R/B retire handshakes.
// slave: the order controller; master: address generator/AXI side.
interface vlsu_axi_order_if;
  logic us_ar_valid_i;
  logic us_ar_ready_o;
  logic ar_valid_o;
  logic ar_ready_i;
  logic us_aw_valid_i;
  logic us_aw_ready_o;
  logic aw_valid_o;
  logic aw_ready_i;
  logic r_valid_i;
  logic r_ready_i;
  logic r_last_i;
  logic b_valid_i;
  logic b_ready_i;

  modport slave (
    input  us_ar_valid_i,
    output us_ar_ready_o,
    output ar_valid_o,
    input  ar_ready_i,
    input  us_aw_valid_i,
    output us_aw_ready_o,
    output aw_valid_o,
    input  aw_ready_i,
    input  r_valid_i,
    input  r_ready_i,
    input  r_last_i,
    input  b_valid_i,
    input  b_ready_i
  );

  modport master (
    output us_ar_valid_i,
    input  us_ar_ready_o,
    input  ar_valid_o,
    output ar_ready_i,
    output us_aw_valid_i,
    input  us_aw_ready_o,
    input  aw_valid_o,
    output aw_ready_i,
    output r_valid_i,
    output r_ready_i,
    output r_last_i,
    output b_valid_i,
    output b_ready_i
  );
endinterface

// File: rtl/vlsu_axi_order_ctrl.sv
// Vector LSU AR/AW issue gate: outstanding limits, ld/st ordering, fence.
// Ports: clk_i/rst_ni, ordering_en_i, fence_req_i/fence_done_o, bus, counts, idle_o, protocol_err_o.
module vlsu_axi_order_ctrl #(
  parameter  int unsigned MaxOutstanding = 8,
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ordering_en_i,
  input  logic                fence_req_i,
  output logic                fence_done_o,
  vlsu_axi_order_if.slave     bus,
  output logic [CntWidth-1:0] rd_outstanding_o,
  output logic [CntWidth-1:0] wr_outstanding_o,
  output logic                idle_o,
  output logic                protocol_err_o
);

  typedef enum logic [1:0] {
    IDLE,
    AR_HOLD,
    AW_HOLD,
    BOTH_HOLD
  } state_e;

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

  state_e state_q, state_d;
  logic [CntWidth-1:0] rd_q, rd_d;
  logic [CntWidth-1:0] wr_q, wr_d;
  logic prio_q, prio_d;
  logic err_q, err_d;
  logic fdone_q;

  logic ar_hold, aw_hold;
  logic ar_elig, aw_elig;
  logic ar_gnt, aw_gnt;
  logic ar_valid, aw_valid;
  logic ar_fire, aw_fire;
  logic r_ret, b_ret;
  logic quiet;

  assign ar_hold = (state_q == AR_HOLD) || (state_q == BOTH_HOLD);
  assign aw_hold = (state_q == AW_HOLD) || (state_q == BOTH_HOLD);

  assign ar_elig = bus.us_ar_valid_i && !fence_req_i
                && (rd_q < MaxCnt)
                && (!ordering_en_i || wr_q == '0);
  assign aw_elig = bus.us_aw_valid_i && !fence_req_i
                && (wr_q < MaxCnt)
                && (!ordering_en_i || rd_q == '0);

  // With ordering on, a held channel locks out the other, and a
  // simultaneous request is arbitrated by prio_q (0 = AR).
  assign ar_gnt = !ordering_en_i
               || (!aw_hold && (!aw_elig || !prio_q));
  assign aw_gnt = !ordering_en_i
               || (!ar_hold && (!ar_elig || prio_q));

  assign ar_valid = (ar_elig && ar_gnt) || ar_hold;
  assign aw_valid = (aw_elig && aw_gnt) || aw_hold;

  assign bus.ar_valid_o    = ar_valid;
  assign bus.aw_valid_o    = aw_valid;
  assign bus.us_ar_ready_o = bus.ar_ready_i && ar_valid;
  assign bus.us_aw_ready_o = bus.aw_ready_i && aw_valid;

  assign ar_fire = ar_valid && bus.ar_ready_i;
  assign aw_fire = aw_valid && bus.aw_ready_i;
  assign r_ret   = bus.r_valid_i && bus.r_ready_i && bus.r_last_i;
  assign b_ret   = bus.b_valid_i && bus.b_ready_i;

  assign quiet = (rd_q == '0) && (wr_q == '0) && (state_q == IDLE);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    err_d = err_q;
    unique case ({ar_fire, r_ret})
      2'b10: rd_d = rd_q + 1'b1;
      2'b01: begin
        if (rd_q == '0) err_d = 1'b1;
        else            rd_d  = rd_q - 1'b1;
      end
      default: ;
    endcase
    unique case ({aw_fire, b_ret})
      2'b10: wr_d = wr_q + 1'b1;
      2'b01: begin
        if (wr_q == '0) err_d = 1'b1;
        else            wr_d  = wr_q - 1'b1;
      end
      default: ;
    endcase
  end

  // A presented valid that is not taken must stay up next cycle.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q ^ ar_fire ^ aw_fire;
    unique case ({ar_valid && !bus.ar_ready_i,
                  aw_valid && !bus.aw_ready_i})
      2'b00: state_d = IDLE;
      2'b10: state_d = AR_HOLD;
      2'b01: state_d = AW_HOLD;
      2'b11: state_d = BOTH_HOLD;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      prio_q  <= 1'b0;
      err_q   <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      prio_q  <= prio_d;
      err_q   <= err_d;
      fdone_q <= fence_req_i && quiet;
    end
  end

  assign rd_outstanding_o = rd_q;
  assign wr_outstanding_o = wr_q;
  assign idle_o           = quiet;
  assign protocol_err_o   = err_q;
  assign fence_done_o     = fdone_q;

endmodule

// File: tb/tb_vlsu_axi_order_ctrl.sv
// Directed bench for vlsu_axi_order_ctrl with a cycle model.
// Model is checked every cycle; literal checks pin the directed points.
module tb_vlsu_axi_order_ctrl;
  localparam int MAX = 3;
  localparam int CW  = $clog2(MAX + 1);

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic ord = 1'b0;
  logic fence = 1'b0;
  logic fdone, idle, perr;
  logic [CW-1:0] rd_o, wr_o;

  int vectors = 0;
  int miscompares = 0;

  vlsu_axi_order_if bus();

  vlsu_axi_order_ctrl #(.MaxOutstanding(MAX)) u_dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .ordering_en_i    (ord),
    .fence_req_i      (fence),
    .fence_done_o     (fdone),
    .bus              (bus),
    .rd_outstanding_o (rd_o),
    .wr_outstanding_o (wr_o),
    .idle_o           (idle),
    .protocol_err_o   (perr)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int m_rd, m_wr;
  bit m_ar_pend, m_aw_pend, m_prio, m_err, m_fdone;

  function automatic bit m_ar_elig();
    return bus.us_ar_valid_i && !fence && m_rd < MAX
        && (!ord || m_wr == 0);
  endfunction

  function automatic bit m_aw_elig();
    return bus.us_aw_valid_i && !fence && m_wr < MAX
        && (!ord || m_rd == 0);
  endfunction

  function automatic bit m_ar_show();
    if (m_ar_pend) return 1'b1;
    if (!m_ar_elig()) return 1'b0;
    if (!ord) return 1'b1;
    if (m_aw_pend) return 1'b0;
    return !(m_aw_elig() && m_prio);
  endfunction

  function automatic bit m_aw_show();
    if (m_aw_pend) return 1'b1;
    if (!m_aw_elig()) return 1'b0;
    if (!ord) return 1'b1;
    if (m_ar_pend) return 1'b0;
    return !(m_ar_elig() && !m_prio);
  endfunction

  function automatic bit m_quiet();
    return m_rd == 0 && m_wr == 0 && !m_ar_pend && !m_aw_pend;
  endfunction

  always @(posedge clk or negedge rst_ni) begin : model
    bit av, wv, arf, awf, rr, br;
    if (!rst_ni) begin
      m_rd = 0; m_wr = 0;
      m_ar_pend = 0; m_aw_pend = 0;
      m_prio = 0; m_err = 0; m_fdone = 0;
    end else begin
      av  = m_ar_show();
      wv  = m_aw_show();
      arf = av && bus.ar_ready_i;
      awf = wv && bus.aw_ready_i;
      rr  = bus.r_valid_i && bus.r_ready_i && bus.r_last_i;
      br  = bus.b_valid_i && bus.b_ready_i;
      m_fdone = fence && m_quiet();
      if (arf && !rr) m_rd++;
      else if (!arf && rr) begin
        if (m_rd == 0) m_err = 1;
        else m_rd--;
      end
      if (awf && !br) m_wr++;
      else if (!awf && br) begin
        if (m_wr == 0) m_err = 1;
        else m_wr--;
      end
      m_ar_pend = av && !bus.ar_ready_i;
      m_aw_pend = wv && !bus.aw_ready_i;
      if (arf != awf) m_prio = !m_prio;
    end
  end

  always @(negedge clk) begin
    if (rst_ni) begin
      chk("m_ar_valid", bus.ar_valid_o, m_ar_show());
      chk("m_aw_valid", bus.aw_valid_o, m_aw_show());
      chk("m_us_ar_ready", bus.us_ar_ready_o,
          m_ar_show() && bus.ar_ready_i);
      chk("m_us_aw_ready", bus.us_aw_ready_o,
          m_aw_show() && bus.aw_ready_i);
      chk("m_rd_cnt", rd_o, m_rd);
      chk("m_wr_cnt", wr_o, m_wr);
      chk("m_idle", idle, m_quiet());
      chk("m_err", perr, m_err);
      chk("m_fence_done", fdone, m_fdone);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic r_pulse();
    bus.r_valid_i = 1; bus.r_ready_i = 1; bus.r_last_i = 1;
    cyc();
    bus.r_valid_i = 0; bus.r_ready_i = 0; bus.r_last_i = 0;
  endtask

  task automatic b_pulse();
    bus.b_valid_i = 1; bus.b_ready_i = 1;
    cyc();
    bus.b_valid_i = 0; bus.b_ready_i = 0;
  endtask

  initial begin
    bus.us_ar_valid_i = 0; bus.ar_ready_i = 0;
    bus.us_aw_valid_i = 0; bus.aw_ready_i = 0;
    bus.r_valid_i = 0; bus.r_ready_i = 0; bus.r_last_i = 0;
    bus.b_valid_i = 0; bus.b_ready_i = 0;
    cyc();
    cyc();
    chk("rst_rd", rd_o, 0);
    chk("rst_wr", wr_o, 0);
    chk("rst_idle", idle, 1);
    chk("rst_err", perr, 0);
    chk("rst_fdone", fdone, 0);
    chk("rst_ar_valid", bus.ar_valid_o, 0);
    rst_ni = 1;

    // three ARs up to the limit, then retire-while-full
    cyc();
    bus.us_ar_valid_i = 1; bus.ar_ready_i = 1;
    cyc(); chk("t1_rd1", rd_o, 1);
    cyc(); chk("t1_rd2", rd_o, 2);
    cyc(); chk("t1_rd3", rd_o, 3);
    chk("t1_full_block", bus.ar_valid_o, 0);
    bus.r_valid_i = 1; bus.r_ready_i = 1; bus.r_last_i = 1;
    #1 chk("t1_full_ret_block", bus.ar_valid_o, 0);
    cyc();
    bus.r_valid_i = 0; bus.r_ready_i = 0; bus.r_last_i = 0;
    #1 chk("t1_after_ret_rd", rd_o, 2);
    chk("t1_after_ret_valid", bus.ar_valid_o, 1);
    cyc(); chk("t1_refill", rd_o, 3);
    bus.us_ar_valid_i = 0;
    r_pulse(); chk("t1_dec2", rd_o, 2);
    r_pulse(); chk("t1_dec1", rd_o, 1);
    r_pulse(); chk("t1_dec0", rd_o, 0);
    chk("t1_idle", idle, 1);
    chk("t1_err", perr, 0);

    // ordering: AR waits for outstanding write
    ord = 1;
    bus.us_aw_valid_i = 1; bus.aw_ready_i = 1;
    cyc(); chk("t2_wr1", wr_o, 1);
    bus.us_aw_valid_i = 0;
    bus.us_ar_valid_i = 1; bus.ar_ready_i = 1;
    #1 chk("t2_ar_wait0", bus.ar_valid_o, 0);
    cyc(); chk("t2_ar_wait1", bus.ar_valid_o, 0);
    bus.b_valid_i = 1; bus.b_ready_i = 1;
    #1 chk("t2_ar_wait_bret", bus.ar_valid_o, 0);
    cyc();
    bus.b_valid_i = 0; bus.b_ready_i = 0;
    #1 chk("t2_wr0", wr_o, 0);
    chk("t2_ar_go", bus.ar_valid_o, 1);
    cyc(); chk("t2_rd1", rd_o, 1);
    bus.us_ar_valid_i = 0;
    r_pulse();

    // ordering: both requesting at zero counts, AR first
    bus.us_ar_valid_i = 1; bus.us_aw_valid_i = 1;
    bus.ar_ready_i = 1; bus.aw_ready_i = 1;
    #1 chk("t2_both_ar", bus.ar_valid_o, 1);
    chk("t2_both_aw", bus.aw_valid_o, 0);
    chk("t2_both_aw_rdy", bus.us_aw_ready_o, 0);
    cyc();
    bus.us_ar_valid_i = 0;
    #1 chk("t2_aw_wait", bus.aw_valid_o, 0);
    r_pulse();
    #1 chk("t2_aw_go", bus.aw_valid_o, 1);
    cyc(); chk("t2_aw_wr1", wr_o, 1);
    bus.us_aw_valid_i = 0;
    b_pulse();

    // ordering: held AR survives fence toggles, AW locked out
    bus.us_ar_valid_i = 1; bus.ar_ready_i = 0;
    bus.us_aw_valid_i = 1; bus.aw_ready_i = 1;
    #1 chk("t3_ar_first", bus.ar_valid_o, 1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      fence = ~fence;
      #1 chk("t3_ar_hold", bus.ar_valid_o, 1);
      chk("t3_aw_off", bus.aw_valid_o, 0);
    end
    fence = 0; bus.ar_ready_i = 1;
    cyc(); chk("t3_ar_fired", rd_o, 1);
    bus.us_ar_valid_i = 0;
    r_pulse();
    #1 chk("t3_aw_go", bus.aw_valid_o, 1);
    cyc();
    bus.us_aw_valid_i = 0;
    b_pulse();

    // fence drain
    ord = 0;
    bus.us_ar_valid_i = 1; bus.us_aw_valid_i = 1;
    cyc();
    bus.us_aw_valid_i = 0;
    cyc();
    chk("t4_rd2", rd_o, 2);
    chk("t4_wr1", wr_o, 1);
    fence = 1;
    bus.us_aw_valid_i = 1;
    #1 chk("t4_no_ar", bus.ar_valid_o, 0);
    chk("t4_no_aw", bus.aw_valid_o, 0);
    cyc(); chk("t4_fd0a", fdone, 0);
    r_pulse();
    b_pulse();
    r_pulse();
    chk("t4_fd0b", fdone, 0);
    cyc(); chk("t4_fd1", fdone, 1);
    cyc(); chk("t4_fd1_hold", fdone, 1);
    bus.us_ar_valid_i = 0; bus.us_aw_valid_i = 0;
    fence = 0;
    #1 chk("t4_fd1_drop", fdone, 1);
    cyc(); chk("t4_fd0c", fdone, 0);

    // protocol error and reset mid-burst
    b_pulse();
    chk("t5_wr_sat", wr_o, 0);
    chk("t5_err", perr, 1);
    cyc(); chk("t5_err_sticky", perr, 1);
    bus.us_ar_valid_i = 1;
    cyc(); chk("t5_rd1", rd_o, 1);
    bus.us_ar_valid_i = 0;
    rst_ni = 0;
    #1 chk("t5_rst_rd", rd_o, 0);
    chk("t5_rst_err", perr, 0);
    chk("t5_rst_idle", idle, 1);
    cyc();
    rst_ni = 1;
    cyc();
    r_pulse();
    chk("t5_late_rd", rd_o, 0);
    chk("t5_late_err", perr, 1);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
